// File: rtl/uart_program_loader.sv
// uart_program_loader
// Boot stage in front of riscv_cpu_unit: receives a program image over an
// 8N1 UART line and writes it word by word into unified memory through the
// core's external write port, holding the core in reset until the load ends.
//
// Frame: SYNC_BYTE, N[7:0], N[15:8], then N little-endian 32-bit words.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   rx            UART serial input (idle high, asynchronous to clk)
//   Ext_MemWrite  one-cycle write strobe to the core memory port
//   Ext_WriteData word being written (holds last value otherwise)
//   Ext_DataAdr   byte address of the write
//   cpu_reset     active-high reset to the core
//   load_done     high while the loaded program runs
//   err           bit0 framing error, bit1 length error (sticky)
//   words_loaded  words written in the current load
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned MAX_WORDS    = 64,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        load_done,
    output logic [1:0]  err,
    output logic [15:0] words_loaded
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // rx synchroniser plus one delayed copy for falling-edge detection
    // ------------------------------------------------------------------
    logic rxMeta;
    logic rxSync;
    logic rxSyncPrev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta     <= 1'b1;
            rxSync     <= 1'b1;
            rxSyncPrev <= 1'b1;
        end else begin
            rxMeta     <= rx;
            rxSync     <= rxMeta;
            rxSyncPrev <= rxSync;
        end
    end

    // ------------------------------------------------------------------
    // 8N1 receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_t;

    rxState_t         rxState,   rxStateNext;
    logic [CNT_W-1:0] rxCnt,     rxCntNext;
    logic [2:0]       rxBitIdx,  rxBitIdxNext;
    logic [7:0]       rxShift,   rxShiftNext;
    logic             byteValid, byteValidNext;
    logic             frameError, frameErrorNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxState    <= RX_IDLE;
            rxCnt      <= '0;
            rxBitIdx   <= '0;
            rxShift    <= '0;
            byteValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            rxState    <= rxStateNext;
            rxCnt      <= rxCntNext;
            rxBitIdx   <= rxBitIdxNext;
            rxShift    <= rxShiftNext;
            byteValid  <= byteValidNext;
            frameError <= frameErrorNext;
        end
    end

    // Start bit re-checked at half a bit; data and stop sampled a full bit apart.
    always_comb begin
        rxStateNext    = rxState;
        rxCntNext      = rxCnt;
        rxBitIdxNext   = rxBitIdx;
        rxShiftNext    = rxShift;
        byteValidNext  = 1'b0;
        frameErrorNext = 1'b0;
        unique case (rxState)
            RX_IDLE: begin
                if (rxSyncPrev && !rxSync) begin
                    rxStateNext = RX_START;
                    rxCntNext   = '0;
                end
            end
            RX_START: begin
                if (rxCnt == HALF_LAST) begin
                    rxCntNext    = '0;
                    rxBitIdxNext = '0;
                    rxStateNext  = rxSync ? RX_IDLE : RX_DATA;
                end else begin
                    rxCntNext = rxCnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNext   = '0;
                    rxShiftNext = {rxSync, rxShift[7:1]};
                    if (rxBitIdx == 3'd7) begin
                        rxStateNext = RX_STOP;
                    end else begin
                        rxBitIdxNext = rxBitIdx + 3'd1;
                    end
                end else begin
                    rxCntNext = rxCnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNext      = '0;
                    rxStateNext    = RX_IDLE;
                    byteValidNext  = rxSync;
                    frameErrorNext = !rxSync;
                end else begin
                    rxCntNext = rxCnt + CNT_W'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } loadState_t;

    loadState_t  state, stateNext;
    logic [7:0]  lenLo, lenLoNext;
    logic [15:0] lenN, lenNNext;
    logic [1:0]  byteIdx, byteIdxNext;
    logic [23:0] wordReg, wordRegNext;
    logic        memWriteNext;
    logic [31:0] writeDataNext;
    logic [31:0] dataAdrNext;
    logic        cpuResetNext;
    logic        loadDoneNext;
    logic [1:0]  errNext;
    logic [15:0] wordsLoadedNext;
    logic [15:0] lenRx;
    logic [15:0] wordsInc;

    assign lenRx    = {rxShift, lenLo};
    assign wordsInc = words_loaded + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= WAIT_SYNC;
            lenLo         <= '0;
            lenN          <= '0;
            byteIdx       <= '0;
            wordReg       <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= BASE_ADDR;
            cpu_reset     <= 1'b1;
            load_done     <= 1'b0;
            err           <= '0;
            words_loaded  <= '0;
        end else begin
            state         <= stateNext;
            lenLo         <= lenLoNext;
            lenN          <= lenNNext;
            byteIdx       <= byteIdxNext;
            wordReg       <= wordRegNext;
            Ext_MemWrite  <= memWriteNext;
            Ext_WriteData <= writeDataNext;
            Ext_DataAdr   <= dataAdrNext;
            cpu_reset     <= cpuResetNext;
            load_done     <= loadDoneNext;
            err           <= errNext;
            words_loaded  <= wordsLoadedNext;
        end
    end

    // Outputs are computed for the next state so they are registered and
    // already valid in the first cycle of that state.
    always_comb begin
        stateNext       = state;
        lenLoNext       = lenLo;
        lenNNext        = lenN;
        byteIdxNext     = byteIdx;
        wordRegNext     = wordReg;
        writeDataNext   = Ext_WriteData;
        dataAdrNext     = Ext_DataAdr;
        cpuResetNext    = cpu_reset;
        loadDoneNext    = load_done;
        errNext         = err;
        wordsLoadedNext = words_loaded;
        memWriteNext    = 1'b0;

        case (state)
            WAIT_SYNC, DONE: begin
                if (byteValid && rxShift == SYNC_BYTE) begin
                    stateNext       = LEN_LO;
                    cpuResetNext    = 1'b1;
                    loadDoneNext    = 1'b0;
                    wordsLoadedNext = '0;
                    dataAdrNext     = BASE_ADDR;
                end
            end
            LEN_LO: begin
                if (byteValid) begin
                    lenLoNext = rxShift;
                    stateNext = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byteValid) begin
                    lenNNext = lenRx;
                    if (lenRx == 16'd0) begin
                        stateNext    = DONE;
                        cpuResetNext = 1'b0;
                        loadDoneNext = 1'b1;
                    end else if (lenRx > 16'(MAX_WORDS)) begin
                        stateNext  = ERROR;
                        errNext[1] = 1'b1;
                    end else begin
                        stateNext   = DATA;
                        byteIdxNext = '0;
                    end
                end
            end
            DATA: begin
                if (byteValid) begin
                    // First byte ends up in bits 7:0 of the assembled word.
                    byteIdxNext = byteIdx + 2'd1;
                    if (byteIdx == 2'd3) begin
                        writeDataNext = {rxShift, wordReg};
                        stateNext     = WRITE;
                    end else begin
                        wordRegNext = {rxShift, wordReg[23:8]};
                    end
                end
            end
            WRITE: begin
                wordsLoadedNext = wordsInc;
                if (wordsInc == lenN) begin
                    stateNext    = DONE;
                    cpuResetNext = 1'b0;
                    loadDoneNext = 1'b1;
                end else begin
                    dataAdrNext = Ext_DataAdr + 32'd4;
                    stateNext   = DATA;
                end
            end
            ERROR: begin
                cpuResetNext = 1'b1;
                loadDoneNext = 1'b0;
            end
            default: begin
                stateNext = WAIT_SYNC;
            end
        endcase

        // Framing errors only matter once a load has started.
        if (frameError && (state == LEN_LO || state == LEN_HI ||
                           state == DATA || state == ERROR)) begin
            stateNext    = ERROR;
            errNext[0]   = 1'b1;
            cpuResetNext = 1'b1;
            loadDoneNext = 1'b0;
        end

        memWriteNext = (stateNext == WRITE);
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed frames from the
// block's test plan followed by randomized loads compared against a simple
// frame-level model (expected writes are BASE+4*i with the sent words).
module tb_uart_program_loader;

    localparam int unsigned CPB       = 4;
    localparam logic [31:0] BASE      = 32'h0;
    localparam int unsigned MAXW      = 64;
    localparam logic [7:0]  SYNC      = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        cpu_reset;
    logic        load_done;
    logic [1:0]  err;
    logic [15:0] words_loaded;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData),
        .Ext_DataAdr  (Ext_DataAdr),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;

    // Observed writes and the longest strobe run seen.
    logic [63:0] wrLog[$];
    int runLen = 0;
    int maxRun = 0;

    always @(negedge clk) begin
        if (Ext_MemWrite === 1'b1) begin
            wrLog.push_back({Ext_DataAdr, Ext_WriteData});
            runLen = runLen + 1;
            if (runLen > maxRun) maxRun = runLen;
        end else begin
            runLen = 0;
        end
    end

    logic [7:0]  txQ[$];
    logic [63:0] expWr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic sendTx();
        foreach (txQ[i]) sendByte(txQ[i]);
        txQ.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic pushWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) txQ.push_back(8'(w >> (8 * i)));
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        wrLog.delete();
        expWr.delete();
        maxRun = 0;
        reset  = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_memwrite"}, 64'(Ext_MemWrite), 64'(1'b0));
        check({tag, "_wdata"},    64'(Ext_WriteData), 64'(32'h0));
        check({tag, "_adr"},      64'(Ext_DataAdr), 64'(BASE));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1'b1));
        check({tag, "_load_done"}, 64'(load_done), 64'(1'b0));
        check({tag, "_err"},      64'(err), 64'(2'b00));
        check({tag, "_words"},    64'(words_loaded), 64'(16'd0));
    endtask

    task automatic checkState(input string tag, input logic expCpu, input logic expDone,
                              input logic [1:0] expErr, input logic [15:0] expWords);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(expCpu));
        check({tag, "_load_done"}, 64'(load_done), 64'(expDone));
        check({tag, "_err"},       64'(err), 64'(expErr));
        check({tag, "_words"},     64'(words_loaded), 64'(expWords));
    endtask

    task automatic checkWrites(input string tag);
        check({tag, "_wr_count"}, 64'(wrLog.size()), 64'(expWr.size()));
        for (int i = 0; i < expWr.size() && i < wrLog.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wrLog[i], expWr[i]);
        if (expWr.size() > 0) check({tag, "_strobe_width"}, 64'(maxRun), 64'd1);
    endtask

    initial begin
        logic [7:0]  g;
        logic [31:0] w;
        int          n;
        int          ng;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        #1;
        checkResetValues("in_reset");

        // Idle line for 200 cycles
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_wr_count", 64'(wrLog.size()), 64'd0);
        checkState("idle", 1'b1, 1'b0, 2'b00, 16'd0);

        // Normal two-word load
        txQ = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hA0, 8'h00};
        sendTx();
        expWr = '{{32'd0, 32'h00500513}, {32'd4, 32'h00A005B3}};
        checkWrites("normal");
        checkState("normal", 1'b0, 1'b1, 2'b00, 16'd2);

        // Reload from DONE
        wrLog.delete();
        maxRun = 0;
        sendByte(8'hA5);
        checkState("reload_sync", 1'b1, 1'b0, 2'b00, 16'd0);
        check("reload_sync_adr", 64'(Ext_DataAdr), 64'(BASE));
        txQ = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sendTx();
        expWr = '{{32'd0, 32'h12345678}};
        checkWrites("reload");
        checkState("reload", 1'b0, 1'b1, 2'b00, 16'd1);

        // Garbage before sync
        applyReset();
        txQ = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        sendTx();
        expWr = '{{32'd0, 32'hDEADBEEF}};
        checkWrites("garbage");
        checkState("garbage", 1'b0, 1'b1, 2'b00, 16'd1);

        // Zero length
        applyReset();
        txQ = '{8'hA5, 8'h00, 8'h00};
        sendTx();
        checkWrites("zero_len");
        checkState("zero_len", 1'b0, 1'b1, 2'b00, 16'd0);

        // Oversize length, later bytes ignored
        applyReset();
        txQ = '{8'hA5, 8'h41, 8'h00};
        sendTx();
        checkState("oversize", 1'b1, 1'b0, 2'b10, 16'd0);
        txQ = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        sendTx();
        checkWrites("oversize_after");
        checkState("oversize_after", 1'b1, 1'b0, 2'b10, 16'd0);

        // Short glitch in the middle of the data phase
        applyReset();
        txQ = '{8'hA5, 8'h01, 8'h00};
        sendTx();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check("glitch_wr_count", 64'(wrLog.size()), 64'd0);
        checkState("glitch", 1'b1, 1'b0, 2'b00, 16'd0);
        txQ = '{8'h21, 8'h43, 8'h65, 8'h87};
        sendTx();
        expWr = '{{32'd0, 32'h87654321}};
        checkWrites("glitch_load");
        checkState("glitch_load", 1'b0, 1'b1, 2'b00, 16'd1);

        // Framing error during DATA
        applyReset();
        txQ = '{8'hA5, 8'h02, 8'h00, 8'h13};
        sendTx();
        sendByte(8'h05, 1'b0);
        repeat (4) @(negedge clk);
        checkState("frame_err", 1'b1, 1'b0, 2'b01, 16'd0);
        txQ = '{8'h50, 8'h00, 8'hB3, 8'h05, 8'hA0, 8'h00, 8'h11};
        sendTx();
        checkWrites("frame_err_after");
        checkState("frame_err_after", 1'b1, 1'b0, 2'b01, 16'd0);

        // Reset in the middle of the second word
        applyReset();
        txQ = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h10, 8'h20};
        sendTx();
        check("midload_adr_before", 64'(Ext_DataAdr), 64'(BASE + 32'd4));
        check("midload_wdata_before", 64'(Ext_WriteData), 64'(32'h89ABCDEF));
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("midload_reset");
        repeat (2) @(negedge clk);

        // Randomized well-formed loads against the frame model
        for (int it = 0; it < 4; it++) begin
            applyReset();
            ng = int'($urandom_range(3, 0));
            for (int k = 0; k < ng; k++) begin
                do g = 8'($urandom); while (g == SYNC);
                txQ.push_back(g);
            end
            n = int'($urandom_range(4, 1));
            txQ.push_back(SYNC);
            txQ.push_back(8'(n));
            txQ.push_back(8'(n >> 8));
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                pushWord(w);
                expWr.push_back({BASE + 32'(4 * k), w});
            end
            sendTx();
            checkWrites($sformatf("rand%0d", it));
            checkState($sformatf("rand%0d", it), 1'b0, 1'b1, 2'b00, 16'(n));
        end

        // Randomized oversize length
        applyReset();
        n = int'($urandom_range(1000, MAXW + 1));
        txQ = '{SYNC, 8'(n), 8'(n >> 8)};
        pushWord($urandom);
        sendTx();
        checkWrites("rand_oversize");
        checkState("rand_oversize", 1'b1, 1'b0, 2'b10, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
